conv_frame_sequencer: RTL
=========================

Name: conv_frame_sequencer

Overview:
- Frame-level controller for the 2-D convolution engine (weights via addr/w_en port, pixels via x/valid port, results via y/valid).
- Per start command, reads KERNEL_SIZE² weights from weight RAM and loads them into the engine, then streams one DATA_SIZE×DATA_SIZE frame from pixel RAM with no gaps.
- Collects and tags the engine results with output row/column, flags the last result, signals completion.
- Watchdog flags an engine that stops producing results.

Parameters:
- KERNEL_SIZE, 5, kernel edge length
- WEIGHT_BW, 8, weight width
- DATA_BW, 8, pixel width
- ADDR_BW, 5, engine/weight-RAM address width (must hold KERNEL_SIZE²-1)
- SUM_BW, 16, result width
- DATA_SIZE, 32, input frame edge length
- STRIDE, 1, engine stride (used only for output count)
- PIX_ADDR_BW, 10, pixel-RAM address width (must hold DATA_SIZE²-1)
- OUT_BW, 5, row/col tag width (must hold OUT_SIZE-1); OUT_SIZE=(DATA_SIZE-KERNEL_SIZE)/STRIDE+1
- TIMEOUT, 2048, maximum DRAIN cycles
- TO_BW, 12, watchdog counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_start  in  1  start pulse; accepted only in IDLE
- o_busy  out  1  high in LOAD_W, STREAM, DRAIN
- o_done  out  1  one-cycle pulse in DONE
- o_timeout  out  1  sticky watchdog flag; cleared by reset or an accepted i_start
- o_wmem_rd  out  1  weight RAM read enable
- o_wmem_addr  out  ADDR_BW  weight RAM address
- i_wmem_data  in  WEIGHT_BW  read data, 1-cycle latency
- o_xmem_rd  out  1  pixel RAM read enable
- o_xmem_addr  out  PIX_ADDR_BW  pixel RAM address, raster order
- i_xmem_data  in  DATA_BW  read data, 1-cycle latency
- o_eng_w_en / o_eng_addr / o_eng_w  out  1/ADDR_BW/WEIGHT_BW  engine weight load
- o_eng_valid / o_eng_x  out  1/DATA_BW  engine pixel stream
- i_eng_valid / i_eng_y  in  1/SUM_BW  engine result
- o_y_valid / o_y  out  1/SUM_BW  registered result
- o_y_row / o_y_col  out  OUT_BW  output coordinate of o_y
- o_y_last  out  1  with final result of frame

Behaviour:
- Reset: FSM=IDLE; all outputs and counters 0. Reset mid-operation aborts the frame with no done pulse.
- FSM states: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: on i_start, clear o_timeout, result counter and row/col, then go to LOAD_W. While busy or in DONE, i_start is ignored.
- LOAD_W: o_wmem_rd=1 with addr 0..K²-1 on K² consecutive cycles. One cycle later, o_eng_w_en=1 with o_eng_addr=delayed addr and o_eng_w=i_wmem_data. After the read of addr K²-1, go to STREAM.
- STREAM: o_xmem_rd=1 with addr 0..DATA_SIZE²-1 on consecutive cycles. One cycle later, o_eng_valid=1 with o_eng_x=i_xmem_data, for exactly DATA_SIZE² contiguous cycles.
  - The first o_eng_valid follows the last o_eng_w_en by exactly 1 cycle; the two are never high together.
  - After the last read, go to DRAIN; the final o_eng_valid is issued in the first DRAIN cycle.
- Result capture (LOAD_W/STREAM/DRAIN): when i_eng_valid=1, o_y<=i_eng_y and o_y_valid<=1 next cycle.
  - Row/col increment after each result; col wraps at OUT_SIZE-1 and row then increments.
  - o_y_last=1 when the result count reaches OUT_SIZE².
  - i_eng_valid outside busy states is ignored.
  - o_y_valid deasserted resets o_y to 0.
- DRAIN: watchdog counts cycles from entry.
  - Result count == OUT_SIZE² (last result registered): go to DONE.
  - Watchdog reaches TIMEOUT first: set o_timeout, go to DONE.
  - Both in the same cycle: completion wins, o_timeout stays 0.
- DONE: o_done=1 for one cycle, then IDLE.
- No backpressure on any interface: the engine pipeline cannot stall, and both RAMs are assumed always ready.
- All counters saturate-free. Widths are sized by parameters; the implementation asserts the sizing constraints.

Decomposition:
- Shared package conv_pkg:
  - FSM state enum: IDLE, LOAD_W, STREAM, DRAIN, DONE
  - derived constants OUT_SIZE, N_W=KERNEL_SIZE², N_X=DATA_SIZE²
- One sub-module, conv_out_tagger: result register, row/col counters, result count and last flag. Shared with future multi-channel sequencers.

Test Plan:
- All weights 1, all pixels 1, behavioural engine model → 784 results, each o_y=25; final result has row=27, col=27, o_y_last=1; o_done one cycle later; o_timeout=0.
- Weight-load trace → o_wmem_addr 0..24 on 25 consecutive cycles; o_eng_w_en for 25 cycles with addr lag 1; first o_eng_valid exactly 1 cycle after the last w_en; 1024 contiguous o_eng_valid.
- Identity kernel (weight 1 at addr 12, else 0), pixel(r,c)=(r+c) mod 64 → o_y at (row,col) equals (row+col+4) mod 64 for all 784 results.
- Engine model never asserts i_eng_valid → o_timeout=1 and o_done pulse exactly 2048 cycles after DRAIN entry; next i_start clears o_timeout.
- i_start pulsed during LOAD_W and STREAM → ignored; pixel read sequence is undisturbed; single o_done.
- rst asserted mid-STREAM (addr 500) → all outputs 0 asynchronously, no o_done; a fresh start then completes the first scenario correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution frame sequencer family.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } conv_state_t;

    function automatic int calc_out_size(input int data_size, input int kernel_size,
                                         input int stride);
        return (data_size - kernel_size) / stride + 1;
    endfunction

    localparam int KERNEL_SIZE_DEF = 5;
    localparam int DATA_SIZE_DEF   = 32;
    localparam int STRIDE_DEF      = 1;
    localparam int OUT_SIZE        = calc_out_size(DATA_SIZE_DEF, KERNEL_SIZE_DEF, STRIDE_DEF);
    localparam int N_W             = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
    localparam int N_X             = DATA_SIZE_DEF * DATA_SIZE_DEF;

endpackage

// File: rtl/conv_out_tagger.sv
// Registers engine results and tags each one with its raster (row, col) position;
// flags the final result of the frame and reports when the frame is complete.
module conv_out_tagger
    import conv_pkg::*;
#(
    parameter int SUM_BW  = 16,
    parameter int OUT_BW  = 5,
    parameter int OUT_DIM = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [SUM_BW-1:0] y_i,
    output logic              y_valid_o,
    output logic [SUM_BW-1:0] y_o,
    output logic [OUT_BW-1:0] row_o,
    output logic [OUT_BW-1:0] col_o,
    output logic              last_o,
    output logic              complete_o
);

    localparam int NUM_OUT = OUT_DIM * OUT_DIM;
    localparam int CNT_BW  = $clog2(NUM_OUT + 1);
    localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(NUM_OUT - 1);
    localparam logic [CNT_BW-1:0] CNT_FULL = CNT_BW'(NUM_OUT);
    localparam logic [OUT_BW-1:0] COL_LAST = OUT_BW'(OUT_DIM - 1);

    logic [OUT_BW-1:0] row_q, row_d, col_q, col_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic              y_valid_q, y_valid_d, last_q, last_d;
    logic [SUM_BW-1:0] y_q, y_d;
    logic [OUT_BW-1:0] y_row_q, y_row_d, y_col_q, y_col_d;

    // row_q/col_q hold the coordinate the next result will carry
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        y_valid_d = capture_i;
        y_d       = '0;
        y_row_d   = '0;
        y_col_d   = '0;
        last_d    = 1'b0;
        if (capture_i) begin
            y_d     = y_i;
            y_row_d = row_q;
            y_col_d = col_q;
            last_d  = (cnt_q == CNT_LAST);
            cnt_d   = cnt_q + CNT_BW'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + OUT_BW'(1);
            end else begin
                col_d = col_q + OUT_BW'(1);
            end
        end
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            y_q       <= '0;
            y_row_q   <= '0;
            y_col_q   <= '0;
            last_q    <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
            y_row_q   <= y_row_d;
            y_col_q   <= y_col_d;
            last_q    <= last_d;
        end
    end

    assign y_valid_o  = y_valid_q;
    assign y_o        = y_q;
    assign row_o      = y_row_q;
    assign col_o      = y_col_q;
    assign last_o     = last_q;
    assign complete_o = (cnt_q == CNT_FULL);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 2-D convolution engine: loads the kernel, streams one
// frame gap-free, tags results, and guards the drain phase with a watchdog.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 5,
    parameter int WEIGHT_BW   = 8,
    parameter int DATA_BW     = 8,
    parameter int ADDR_BW     = 5,
    parameter int SUM_BW      = 16,
    parameter int DATA_SIZE   = 32,
    parameter int STRIDE      = 1,
    parameter int PIX_ADDR_BW = 10,
    parameter int OUT_BW      = 5,
    parameter int TIMEOUT     = 2048,
    parameter int TO_BW       = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout,
    output logic                   o_wmem_rd,
    output logic [ADDR_BW-1:0]     o_wmem_addr,
    input  logic [WEIGHT_BW-1:0]   i_wmem_data,
    output logic                   o_xmem_rd,
    output logic [PIX_ADDR_BW-1:0] o_xmem_addr,
    input  logic [DATA_BW-1:0]     i_xmem_data,
    output logic                   o_eng_w_en,
    output logic [ADDR_BW-1:0]     o_eng_addr,
    output logic [WEIGHT_BW-1:0]   o_eng_w,
    output logic                   o_eng_valid,
    output logic [DATA_BW-1:0]     o_eng_x,
    input  logic                   i_eng_valid,
    input  logic [SUM_BW-1:0]      i_eng_y,
    output logic                   o_y_valid,
    output logic [SUM_BW-1:0]      o_y,
    output logic [OUT_BW-1:0]      o_y_row,
    output logic [OUT_BW-1:0]      o_y_col,
    output logic                   o_y_last
);

    localparam int NUM_W   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NUM_X   = DATA_SIZE * DATA_SIZE;
    localparam int OUT_DIM = calc_out_size(DATA_SIZE, KERNEL_SIZE, STRIDE);
    localparam logic [ADDR_BW-1:0]     W_LAST  = ADDR_BW'(NUM_W - 1);
    localparam logic [PIX_ADDR_BW-1:0] X_LAST  = PIX_ADDR_BW'(NUM_X - 1);
    localparam logic [TO_BW-1:0]       TO_LAST = TO_BW'(TIMEOUT - 1);

    if (NUM_W - 1 >= 2 ** ADDR_BW) begin : g_chk_addr_bw
        $error("ADDR_BW cannot hold KERNEL_SIZE**2-1");
    end
    if (NUM_X - 1 >= 2 ** PIX_ADDR_BW) begin : g_chk_pix_bw
        $error("PIX_ADDR_BW cannot hold DATA_SIZE**2-1");
    end
    if (OUT_DIM - 1 >= 2 ** OUT_BW) begin : g_chk_out_bw
        $error("OUT_BW cannot hold OUT_SIZE-1");
    end
    if (TIMEOUT < 1 || TIMEOUT - 1 >= 2 ** TO_BW) begin : g_chk_to_bw
        $error("TO_BW cannot hold TIMEOUT-1");
    end

    conv_state_t            state_q, state_d;
    logic [ADDR_BW-1:0]     w_cnt_q, w_cnt_d;
    logic [PIX_ADDR_BW-1:0] x_cnt_q, x_cnt_d;
    logic [TO_BW-1:0]       to_cnt_q, to_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   start_acc, busy, res_complete;
    logic                   eng_w_en_q, eng_valid_q;
    logic [ADDR_BW-1:0]     eng_addr_q;

    assign busy = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);

    // Counters return to 0 on phase exit so idle addresses read as 0
    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        x_cnt_d   = x_cnt_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    timeout_d = 1'b0;
                    w_cnt_d   = '0;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                w_cnt_d = w_cnt_q + ADDR_BW'(1);
                if (w_cnt_q == W_LAST) begin
                    w_cnt_d = '0;
                    x_cnt_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                x_cnt_d = x_cnt_q + PIX_ADDR_BW'(1);
                if (x_cnt_q == X_LAST) begin
                    x_cnt_d  = '0;
                    to_cnt_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                to_cnt_d = to_cnt_q + TO_BW'(1);
                // Completion takes priority over a simultaneous watchdog expiry
                if (res_complete) begin
                    state_d = DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                to_cnt_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            x_cnt_q     <= '0;
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            eng_w_en_q  <= 1'b0;
            eng_addr_q  <= '0;
            eng_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            x_cnt_q     <= x_cnt_d;
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
            eng_w_en_q  <= (state_q == LOAD_W);
            eng_addr_q  <= w_cnt_q;
            eng_valid_q <= (state_q == STREAM);
        end
    end

    // RAM read data lands one cycle after the request, aligned with the delayed strobes
    assign o_busy      = busy;
    assign o_done      = (state_q == DONE);
    assign o_timeout   = timeout_q;
    assign o_wmem_rd   = (state_q == LOAD_W);
    assign o_wmem_addr = w_cnt_q;
    assign o_xmem_rd   = (state_q == STREAM);
    assign o_xmem_addr = x_cnt_q;
    assign o_eng_w_en  = eng_w_en_q;
    assign o_eng_addr  = eng_addr_q;
    assign o_eng_w     = eng_w_en_q ? i_wmem_data : '0;
    assign o_eng_valid = eng_valid_q;
    assign o_eng_x     = eng_valid_q ? i_xmem_data : '0;

    conv_out_tagger #(
        .SUM_BW  (SUM_BW),
        .OUT_BW  (OUT_BW),
        .OUT_DIM (OUT_DIM)
    ) u_tagger (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (start_acc),
        .capture_i  (busy && i_eng_valid),
        .y_i        (i_eng_y),
        .y_valid_o  (o_y_valid),
        .y_o        (o_y),
        .row_o      (o_y_row),
        .col_o      (o_y_col),
        .last_o     (o_y_last),
        .complete_o (res_complete)
    );

endmodule
